// File: rtl/vx_mem_load_sink.sv
// vx_mem_load_sink: receives loader cachelines into a FIFO and writes them to memory; VX_MEM_LOAD_STATS_EN adds line/stall counters
module vx_mem_load_sink #(
    parameter int                    CL_WIDTH   = 512,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] INSTR_BASE = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 32'h9000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [1:0]            cacheline_type,
    input  logic [CL_WIDTH-1:0]   cacheline,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [CL_WIDTH-1:0]   mem_wr_data,
    output logic                  load_done,
`ifdef VX_MEM_LOAD_STATS_EN
    output logic [31:0]           instr_lines,
    output logic [31:0]           data_lines,
    output logic [31:0]           stall_cycles,
`endif
    output logic                  load_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(CL_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                state, state_nx;
    logic [CL_WIDTH+1:0]   fifo [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_nx;
    logic                  push, pop, hs, cur_data, end_seen, err_set;
    logic [1:0]            head_type;
    logic [CL_WIDTH-1:0]   head_line;
    logic [ADDR_WIDTH-1:0] instr_ptr, data_ptr, instr_nx, data_nx;

    // Handshakes, FIFO occupancy prediction and drain next-state decode
    always_comb begin
        head_type = fifo[rd_ptr][CL_WIDTH+:2];
        head_line = fifo[rd_ptr][CL_WIDTH-1:0];
        push      = load_valid & load_ready;
        hs        = (state == WRITE) & mem_wr_ready;
        pop       = (count != '0) & ((state == IDLE) | hs);
        count_nx  = count + CW'(push) - CW'(pop);
        state_nx  = pop ? (head_type == 2'd2 ? DONE : head_type == 2'd3 ? IDLE : WRITE)
                        : hs ? IDLE : state;
        instr_nx  = instr_ptr + ((hs & ~cur_data) ? STEP : '0);
        data_nx   = data_ptr + ((hs & cur_data) ? STEP : '0);
        err_set   = (pop & (head_type == 2'd3)) | ((state == DONE) & load_valid) | (push & end_seen);
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {cacheline_type, cacheline};
    end

    // Control state, address pointers and registered write-port outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            load_ready   <= 1'b0;
            instr_ptr    <= INSTR_BASE;
            data_ptr     <= DATA_BASE;
            cur_data     <= 1'b0;
            end_seen     <= 1'b0;
            load_err     <= 1'b0;
            load_done    <= 1'b0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
            load_ready   <= (count_nx != CW'(FIFO_DEPTH)) & (state_nx != DONE);
            instr_ptr    <= instr_nx;
            data_ptr     <= data_nx;
            end_seen     <= end_seen | (push & (cacheline_type == 2'd2));
            load_err     <= load_err | err_set;
            load_done    <= load_done | (state_nx == DONE);
            mem_wr_valid <= state_nx == WRITE;
            if (pop && !head_type[1]) begin
                cur_data    <= head_type[0];
                mem_wr_addr <= head_type[0] ? data_nx : instr_nx;
                mem_wr_data <= head_line;
            end
        end
    end

`ifdef VX_MEM_LOAD_STATS_EN
    // Saturating counters of written lines and loader stall cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_lines  <= '0;
            data_lines   <= '0;
            stall_cycles <= '0;
        end else begin
            if (hs && !cur_data && instr_lines != '1) instr_lines <= instr_lines + 1'b1;
            if (hs && cur_data && data_lines != '1) data_lines <= data_lines + 1'b1;
            if (load_valid && !load_ready && state != DONE && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_vx_mem_load_sink.sv
// tb_vx_mem_load_sink: directed checks of the memory-load sink
module tb_vx_mem_load_sink;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [1:0]   cacheline_type = 2'd0;
    logic [511:0] cacheline = '0;
    logic         mem_wr_valid;
    logic         mem_wr_ready = 1'b0;
    logic [31:0]  mem_wr_addr;
    logic [511:0] mem_wr_data;
    logic         load_done;
    logic         load_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nw = 0;
    int done_cyc = -1;
    logic [31:0]  wa [16];
    logic [511:0] wd [16];
    int           wc [16];

    vx_mem_load_sink dut (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
        .cacheline_type(cacheline_type), .cacheline(cacheline), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Record every accepted memory write and the first cycle load_done is seen
    always @(posedge clk) begin
        cyc++;
        if (reset_n && mem_wr_valid && mem_wr_ready && nw < 16) begin
            wa[nw] = mem_wr_addr;
            wd[nw] = mem_wr_data;
            wc[nw] = cyc;
            nw++;
        end
        if (reset_n && load_done && done_cyc < 0) done_cyc = cyc;
    end

    function automatic logic [511:0] pat(input int s);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(s);
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 512'(load_ready), 512'(0));
        chk({tag, "_valid"}, 512'(mem_wr_valid), 512'(0));
        chk({tag, "_addr"}, 512'(mem_wr_addr), 512'(0));
        chk({tag, "_data"}, mem_wr_data, 512'(0));
        chk({tag, "_done"}, 512'(load_done), 512'(0));
        chk({tag, "_err"}, 512'(load_err), 512'(0));
    endtask

    task automatic do_reset(input logic wr_ready);
        @(negedge clk);
        reset_n = 1'b0;
        load_valid = 1'b0;
        mem_wr_ready = wr_ready;
        repeat (2) @(negedge clk);
        nw = 0;
        done_cyc = -1;
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] t, input logic [511:0] d);
        int k = 0;
        @(negedge clk);
        load_valid = 1'b1;
        cacheline_type = t;
        cacheline = d;
        while (!load_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", 512'(load_ready), 512'(1));
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values, then three back-to-back INSTR lines
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        do_reset(1'b1);
        chk_reset_outputs("rst_held");
        @(negedge clk);
        chk("ready_rise", 512'(load_ready), 512'(1));
        send(2'd0, pat(1));
        send(2'd0, pat(2));
        send(2'd0, pat(3));
        idle(5);
        chk("t1_nw", 512'(nw), 512'(3));
        chk("t1_a0", 512'(wa[0]), 512'(32'h8000_0000));
        chk("t1_a1", 512'(wa[1]), 512'(32'h8000_0040));
        chk("t1_a2", 512'(wa[2]), 512'(32'h8000_0080));
        chk("t1_d0", wd[0], pat(1));
        chk("t1_d2", wd[2], pat(3));
        chk("t1_b2b01", 512'(wc[1] - wc[0]), 512'(1));
        chk("t1_b2b12", 512'(wc[2] - wc[1]), 512'(1));

        // Interleaved INSTR/DATA/INSTR then END
        do_reset(1'b1);
        send(2'd0, pat(10));
        send(2'd1, pat(11));
        send(2'd0, pat(12));
        send(2'd2, pat(13));
        idle(5);
        chk("t2_nw", 512'(nw), 512'(3));
        chk("t2_a0", 512'(wa[0]), 512'(32'h8000_0000));
        chk("t2_a1", 512'(wa[1]), 512'(32'h9000_0000));
        chk("t2_a2", 512'(wa[2]), 512'(32'h8000_0040));
        chk("t2_d1", wd[1], pat(11));
        chk("t2_done_cyc", 512'(done_cyc - wc[2]), 512'(1));
        chk("t2_done", 512'(load_done), 512'(1));
        chk("t2_ready", 512'(load_ready), 512'(0));
        chk("t2_err", 512'(load_err), 512'(0));

        // DATA line offered after END
        @(negedge clk);
        load_valid = 1'b1;
        cacheline_type = 2'd1;
        cacheline = pat(14);
        idle(4);
        chk("t3_err", 512'(load_err), 512'(1));
        chk("t3_nw", 512'(nw), 512'(3));
        chk("t3_done", 512'(load_done), 512'(1));
        chk("t3_ready", 512'(load_ready), 512'(0));

        // Stalled memory: five lines fit, sixth waits, then drain in order
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) send(2'd0, pat(20 + i));
        @(negedge clk);
        cacheline = pat(25);
        chk("t4_full", 512'(load_ready), 512'(0));
        chk("t4_valid", 512'(mem_wr_valid), 512'(1));
        chk("t4_addr_a", 512'(mem_wr_addr), 512'(32'h8000_0000));
        repeat (3) @(negedge clk);
        chk("t4_full_hold", 512'(load_ready), 512'(0));
        chk("t4_addr_b", 512'(mem_wr_addr), 512'(32'h8000_0000));
        chk("t4_data_b", mem_wr_data, pat(20));
        chk("t4_nw0", 512'(nw), 512'(0));
        mem_wr_ready = 1'b1;
        send(2'd0, pat(25));
        idle(10);
        chk("t4_nw", 512'(nw), 512'(6));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_a%0d", i), 512'(wa[i]), 512'(32'h8000_0000 + 32'(64 * i)));
            chk($sformatf("t4_d%0d", i), wd[i], pat(20 + i));
        end

        // Reserved type then INSTR
        do_reset(1'b1);
        send(2'd3, pat(30));
        send(2'd0, pat(31));
        idle(5);
        chk("t5_err", 512'(load_err), 512'(1));
        chk("t5_nw", 512'(nw), 512'(1));
        chk("t5_a0", 512'(wa[0]), 512'(32'h8000_0000));
        chk("t5_d0", wd[0], pat(31));

        // Asynchronous reset mid-write with lines queued
        do_reset(1'b0);
        send(2'd0, pat(40));
        send(2'd0, pat(41));
        send(2'd0, pat(42));
        idle(2);
        chk("t6_valid_pre", 512'(mem_wr_valid), 512'(1));
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("t6_async");
        do_reset(1'b1);
        send(2'd0, pat(43));
        idle(5);
        chk("t6_nw", 512'(nw), 512'(1));
        chk("t6_a0", 512'(wa[0]), 512'(32'h8000_0000));
        chk("t6_d0", wd[0], pat(43));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
